fc_layer: RTL and testbench
===========================

# fc_layer

Fully-connected output stage downstream of the convolution/max-pool engine. After that engine finishes writing the 32×32 layer-1 map (1024 words), this block computes NUM_OUT dot products over the flattened map:
- weights come from a signed weight memory;
- each result gets a per-output bias, rounding and saturation;
- results are written to an output score memory.

## Interface
Parameters:
- NUM_IN, 1024, flattened feature count (layer-1 words)
- NUM_OUT, 10, number of output neurons
- RELU, 0, 1 = clamp negative results to 0 before write

Ports:
- clk  in  1  clock, all flops on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse, begin a run; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at run end
- l1_rd  out  1  feature read strobe
- l1_addr  out  10  feature address, flattened row-major
- l1_data  in  20  feature word, signed 4.16, valid 1 cycle after address
- w_rd  out  1  weight read strobe
- w_addr  out  14  weight/bias address
- w_data  in  20  signed 4.16, valid 1 cycle after address
- fc_wr  out  1  result write strobe
- fc_addr  out  4  output index
- fc_data  out  20  signed 4.16 result

## Operation
- FSM: IDLE → FETCH → BIAS → WAIT0 → WAIT1 → WRITE. WRITE then goes to FETCH (next o) or to DONE; DONE → IDLE.
- IDLE: all strobes low. On start, clear output index o and the accumulator, then go to FETCH.
- FETCH: runs NUM_IN cycles, j = 0..NUM_IN-1.
  - l1_rd = w_rd = 1.
  - l1_addr = j, w_addr = o·NUM_IN + j.
- Datapath per element:
  - Product p = l1_data × w_data, signed 40-bit (8.32), registered 1 cycle after data arrives.
  - acc += sign-extended p; acc is a 48-bit signed accumulator.
  - acc is cleared on FETCH entry (j = 0).
- BIAS: l1_rd = 0, w_rd = 1, w_addr = NUM_OUT·NUM_IN + o.
- WAIT0: bias word captured. Last product accumulates by the end of WAIT1.
- Result computation in WRITE:
  - r = acc[47:16] + acc[15] (round half up, 32-bit signed).
  - Saturate r to [-0x80000, 0x7FFFF].
  - Add the sign-extended bias and saturate again.
  - If RELU = 1 and the result is negative, the result is 0.
- WRITE: fc_wr = 1, fc_addr = o, fc_data = result for exactly one cycle. Then o++; if o = NUM_OUT, go to DONE.
- DONE: done = 1 for one cycle, busy falls in the same cycle, then IDLE.
- start while busy: ignored.
- reset at any time: FSM to IDLE, o and accumulator cleared. No fc_wr is produced for the interrupted neuron.

## Timing
- Reset values: busy, done, l1_rd, w_rd, fc_wr = 0; l1_addr, w_addr, fc_addr, fc_data = 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- start sampled at edge 0 → busy and the first FETCH address appear after edge 1.
- Per output: NUM_IN + 4 cycles.
- Total busy: NUM_OUT·(NUM_IN+4) cycles; 10280 with defaults.
- done coincides with the first cycle after the last WRITE.
- Memories have fixed 1-cycle read latency and no stall. A read strobe is high only in FETCH/BIAS; addresses hold 0 when the strobe is low.

## Structure
- Shared package fc_pkg holds:
  - DATA_W = 20, PROD_W = 40, ACC_W = 48, FRAC = 16;
  - SAT_MAX = 0x7FFFF, SAT_MIN = 0x80000;
  - the FSM state enum;
  - a saturate function.
- One sub-module, fc_mac, holds the product register, 48-bit accumulator (clear/enable), rounding and first saturation.
- The FSM, address generation and bias add stay in fc_layer.

## Test plan
- Saturation: all features 0x10000, all weights 0x10000, biases 0 → ten writes of fc_data = 0x7FFFF.
- Sign and bias:
  - Inputs: feature[5] = 0x20000, weight[3·1024+5] = 0xF0000, bias[3] = 0x08000, others 0.
  - Required: fc_addr 3 carries 0xE8000, all other outputs 0x00000.
  - With RELU = 1, fc_addr 3 carries 0x00000.
- Rounding: feature[0] = 0x00001, weight[0] = 0x08000, rest 0 → output 0 = 0x00001. With weight[0] = 0x07FFF → 0x00000.
- Address/cycle sequence:
  - l1_addr sweeps 0..1023 ten times.
  - w_addr sweeps 0..10239 with 10240+o inserted after each sweep.
  - fc_wr pulses at cycles 1028k+1028 after start, k = 0..9.
  - done at cycle 10281.
- Control robustness:
  - start pulsed again at cycle 300 → ignored.
  - reset asserted at cycle 500 → all outputs 0 next cycle, no fc_wr.
  - A later start produces a complete, correct run.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared widths, saturation limits, FSM state type and saturate helper
// for the fully-connected output stage.
package fc_pkg;
  localparam int DATA_W = 20;
  localparam int PROD_W = 40;
  localparam int ACC_W  = 48;
  localparam int FRAC   = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 20'h80000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BIAS,
    S_WAIT0,
    S_WAIT1,
    S_WRITE,
    S_DONE
  } state_t;

  // Clamp a 32-bit signed value into the signed 4.16 data range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [31:0] v);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = {{(32-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
    lo = {{(32-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};
    if (v > hi) begin
      return SAT_MAX;
    end else if (v < lo) begin
      return SAT_MIN;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction
endpackage

// File: rtl/fc_mac.sv
// Registered 4.16 x 4.16 product feeding a 48-bit accumulator; the sum is
// rounded half-up and saturated back to 4.16.
module fc_mac
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]       rounded;

  // Operands are widened first so the unsigned multiply yields the exact signed 8.32 product.
  always_comb begin
    prod_vld_d = in_valid;
    prod_d     = prod_q;
    if (in_valid) begin
      prod_d = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a} * {{(PROD_W-DATA_W){b[DATA_W-1]}}, b};
    end
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
    rounded = acc_q[ACC_W-1:FRAC] + {31'b0, acc_q[FRAC-1]};
    result  = saturate(rounded);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected output stage: NUM_OUT dot products over the flattened
// layer-1 map, with per-output bias, rounding, saturation and optional ReLU.
module fc_layer
  import fc_pkg::*;
#(
  parameter int NUM_IN  = 1024,
  parameter int NUM_OUT = 10,
  parameter int RELU    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              l1_rd,
  output logic [9:0]        l1_addr,
  input  logic [DATA_W-1:0] l1_data,
  output logic              w_rd,
  output logic [13:0]       w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              fc_wr,
  output logic [3:0]        fc_addr,
  output logic [DATA_W-1:0] fc_data
);

  localparam int J_W = $clog2(NUM_IN);

  state_t            state_q, state_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [3:0]        o_q, o_d;
  logic              start_q, start_d;
  logic              data_vld_q, data_vld_d;
  logic [DATA_W-1:0] bias_q, bias_d;

  logic              busy_q, busy_d, done_q, done_d;
  logic              l1_rd_q, l1_rd_d, w_rd_q, w_rd_d, fc_wr_q, fc_wr_d;
  logic [9:0]        l1_addr_q, l1_addr_d;
  logic [13:0]       w_addr_q, w_addr_d;
  logic [3:0]        fc_addr_q, fc_addr_d;
  logic [DATA_W-1:0] fc_data_q, fc_data_d;

  logic              mac_clear;
  logic [DATA_W-1:0] mac_result, biased, final_res;
  logic [31:0]       bias_sum;

  assign mac_clear = (state_q == S_FETCH) && (j_q == '0);

  fc_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .in_valid (data_vld_q),
    .a        (l1_data),
    .b        (w_data),
    .result   (mac_result)
  );

  always_comb begin
    bias_sum  = {{(32-DATA_W){mac_result[DATA_W-1]}}, mac_result}
              + {{(32-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    biased    = saturate(bias_sum);
    final_res = (RELU != 0 && biased[DATA_W-1]) ? '0 : biased;
  end

  // Outputs are registered from the next state, so they line up with state_q each cycle.
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    o_d        = o_q;
    start_d    = start && (state_q == S_IDLE) && !start_q;
    data_vld_d = l1_rd_q;
    bias_d     = (state_q == S_WAIT0) ? w_data : bias_q;
    done_d     = 1'b0;
    l1_rd_d    = 1'b0;
    l1_addr_d  = '0;
    w_rd_d     = 1'b0;
    w_addr_d   = '0;
    fc_wr_d    = 1'b0;
    fc_addr_d  = '0;
    fc_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_FETCH;
          j_d     = '0;
          o_d     = '0;
        end
      end
      S_FETCH: begin
        if (j_q == J_W'(NUM_IN - 1)) begin
          state_d  = S_BIAS;
          w_rd_d   = 1'b1;
          w_addr_d = 14'(NUM_OUT * NUM_IN + int'(o_q));
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_BIAS:  state_d = S_WAIT0;
      S_WAIT0: state_d = S_WAIT1;
      S_WAIT1: begin
        state_d   = S_WRITE;
        fc_wr_d   = 1'b1;
        fc_addr_d = o_q;
        fc_data_d = final_res;
      end
      S_WRITE: begin
        if (o_q == 4'(NUM_OUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          o_d     = '0;
        end else begin
          state_d = S_FETCH;
          o_d     = o_q + 1'b1;
          j_d     = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FETCH) begin
      l1_rd_d   = 1'b1;
      l1_addr_d = 10'(j_d);
      w_rd_d    = 1'b1;
      w_addr_d  = 14'(int'(o_d) * NUM_IN + int'(j_d));
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      o_q        <= '0;
      start_q    <= 1'b0;
      data_vld_q <= 1'b0;
      bias_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      l1_rd_q    <= 1'b0;
      l1_addr_q  <= '0;
      w_rd_q     <= 1'b0;
      w_addr_q   <= '0;
      fc_wr_q    <= 1'b0;
      fc_addr_q  <= '0;
      fc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      o_q        <= o_d;
      start_q    <= start_d;
      data_vld_q <= data_vld_d;
      bias_q     <= bias_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      l1_rd_q    <= l1_rd_d;
      l1_addr_q  <= l1_addr_d;
      w_rd_q     <= w_rd_d;
      w_addr_q   <= w_addr_d;
      fc_wr_q    <= fc_wr_d;
      fc_addr_q  <= fc_addr_d;
      fc_data_q  <= fc_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign l1_rd   = l1_rd_q;
  assign l1_addr = l1_addr_q;
  assign w_rd    = w_rd_q;
  assign w_addr  = w_addr_q;
  assign fc_wr   = fc_wr_q;
  assign fc_addr = fc_addr_q;
  assign fc_data = fc_data_q;

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer: one RELU=0 and one RELU=1 instance share
// the same memory contents and are compared against an arithmetic model.
module tb_fc_layer;

  localparam int NIN  = 1024;
  localparam int NOUT = 10;
  localparam int RUN  = NOUT * (NIN + 4);
  localparam int WSZ  = NOUT * NIN + NOUT;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy [2];
  logic        done [2];
  logic        l1_rd [2];
  logic [9:0]  l1_addr [2];
  logic [19:0] l1_data [2];
  logic        w_rd [2];
  logic [13:0] w_addr [2];
  logic [19:0] w_data [2];
  logic        fc_wr [2];
  logic [3:0]  fc_addr [2];
  logic [19:0] fc_data [2];

  logic [19:0] l1_mem [NIN];
  logic [19:0] w_mem [WSZ];
  logic [19:0] res [2][NOUT];
  int          wr_cnt [2];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          f_idx;
    logic [19:0] f_val;
    int          w_idx;
    logic [19:0] w_val;
    int          o_idx;
    logic [19:0] bias;
    logic [19:0] exp0;
    logic [19:0] exp1;
  } vec_t;

  vec_t tbl [6];

  fc_layer #(.NUM_IN(NIN), .NUM_OUT(NOUT), .RELU(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .l1_rd(l1_rd[0]), .l1_addr(l1_addr[0]), .l1_data(l1_data[0]),
    .w_rd(w_rd[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .fc_wr(fc_wr[0]), .fc_addr(fc_addr[0]), .fc_data(fc_data[0])
  );

  fc_layer #(.NUM_IN(NIN), .NUM_OUT(NOUT), .RELU(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .l1_rd(l1_rd[1]), .l1_addr(l1_addr[1]), .l1_data(l1_data[1]),
    .w_rd(w_rd[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .fc_wr(fc_wr[1]), .fc_addr(fc_addr[1]), .fc_data(fc_data[1])
  );

  initial forever #5 clk = ~clk;

  // One-cycle-latency memories; unread cycles return noise so stray captures show up.
  always @(posedge clk) begin
    l1_data[0] <= l1_rd[0] ? l1_mem[l1_addr[0]] : 20'($urandom);
    w_data[0]  <= w_rd[0]  ? w_mem[w_addr[0]]   : 20'($urandom);
    l1_data[1] <= l1_rd[1] ? l1_mem[l1_addr[1]] : 20'($urandom);
    w_data[1]  <= w_rd[1]  ? w_mem[w_addr[1]]   : 20'($urandom);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int v);
    l1_mem[tbl[v].f_idx]           = tbl[v].f_val;
    w_mem[tbl[v].w_idx]            = tbl[v].w_val;
    w_mem[NOUT * NIN + tbl[v].o_idx] = tbl[v].bias;
  endtask

  task automatic clearMems();
    for (int j = 0; j < NIN; j++) l1_mem[j] = '0;
    for (int j = 0; j < WSZ; j++) w_mem[j] = '0;
  endtask

  task automatic randomMems(input int wmax);
    for (int j = 0; j < NIN; j++) l1_mem[j] = 20'($urandom);
    for (int j = 0; j < NOUT * NIN; j++) w_mem[j] = 20'(int'($urandom_range(0, 2 * wmax)) - wmax);
    for (int o = 0; o < NOUT; o++) w_mem[NOUT * NIN + o] = 20'($urandom);
  endtask

  function automatic longint clamp20(input longint v);
    if (v > 64'sd524287) return 64'sd524287;
    if (v < -64'sd524288) return -64'sd524288;
    return v;
  endfunction

  // Reference: exact dot product, 48-bit wrap, round half up, clamp, bias, clamp, ReLU.
  function automatic logic [19:0] modelOut(input int o, input bit relu);
    longint acc;
    longint r;
    acc = 0;
    for (int j = 0; j < NIN; j++)
      acc += longint'($signed(l1_mem[j])) * longint'($signed(w_mem[o * NIN + j]));
    acc = (acc <<< 16) >>> 16;
    r = clamp20((acc + 32768) >>> 16);
    r = clamp20(r + longint'($signed(w_mem[NOUT * NIN + o])));
    if (relu && r < 0) r = 0;
    return r[19:0];
  endfunction

  function automatic logic [32:0] actBundle(input int i);
    return {busy[i], done[i], l1_rd[i], l1_addr[i], w_rd[i], w_addr[i], fc_wr[i], fc_addr[i]};
  endfunction

  // Expected control outputs c cycles after the start-sampling edge.
  function automatic logic [32:0] expBundle(input int c);
    logic b, d, lr, wr, fw;
    logic [9:0] la;
    logic [13:0] wa;
    logic [3:0] fa;
    int k, m;
    b = 0; d = 0; lr = 0; wr = 0; fw = 0; la = '0; wa = '0; fa = '0;
    if (c >= 1 && c <= RUN) begin
      b = 1;
      k = (c - 1) / (NIN + 4);
      m = (c - 1) % (NIN + 4);
      if (m < NIN) begin
        lr = 1; la = 10'(m); wr = 1; wa = 14'(k * NIN + m);
      end else if (m == NIN) begin
        wr = 1; wa = 14'(NOUT * NIN + k);
      end else if (m == NIN + 3) begin
        fw = 1; fa = 4'(k);
      end
    end else if (c == RUN + 1) begin
      d = 1;
    end
    return {b, d, lr, la, wr, wa, fw, fa};
  endfunction

  task automatic runOnce(input bit check_seq, input int restart_at, input int reset_at);
    bit finished;
    bit aborted;
    finished = 0;
    aborted  = 0;
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0;
      for (int o = 0; o < NOUT; o++) res[i][o] = 20'hBAD00;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (check_seq) checkOutput("seq_c0", actBundle(0), expBundle(0));
    for (int c = 1; c <= RUN + 20 && !finished && !aborted; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (fc_wr[i]) begin
          if (int'(fc_addr[i]) < NOUT) res[i][fc_addr[i]] = fc_data[i];
          wr_cnt[i]++;
        end
      end
      if (check_seq) checkOutput($sformatf("seq_c%0d", c), actBundle(0), expBundle(c));
      if (done[0]) begin
        finished = 1;
        if (!check_seq) checkOutput("done_cycle", 64'(c), 64'(RUN + 1));
      end
      start = (c == restart_at) ? 1'b1 : 1'b0;
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checkOutput($sformatf("midreset_ctrl%0d", i), actBundle(i), '0);
          checkOutput($sformatf("midreset_data%0d", i), fc_data[i], '0);
          checkOutput($sformatf("midreset_writes%0d", i), 64'(wr_cnt[i]), '0);
        end
        reset   = 1'b0;
        aborted = 1;
      end
    end
    start = 1'b0;
    if (!aborted) checkOutput("done_seen", 64'(finished), 64'd1);
  endtask

  task automatic checkResults(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_wrcount%0d", tag, i), 64'(wr_cnt[i]), 64'(NOUT));
      for (int o = 0; o < NOUT; o++)
        checkOutput($sformatf("%s_relu%0d_out%0d", tag, i, o), res[i][o], modelOut(o, i == 1));
    end
  endtask

  initial begin
    tbl[0] = '{5,  20'h20000, 3 * NIN + 5,  20'hF0000, 3, 20'h08000, 20'hE8000, 20'h00000};
    tbl[1] = '{0,  20'h00001, 0,            20'h08000, 0, 20'h00000, 20'h00001, 20'h00001};
    tbl[2] = '{0,  20'h00001, 1 * NIN + 0,  20'h07FFF, 1, 20'h00000, 20'h00000, 20'h00000};
    tbl[3] = '{9,  20'h18000, 7 * NIN + 9,  20'h30000, 7, 20'hFC000, 20'h44000, 20'h44000};
    tbl[4] = '{20, 20'h7FFFF, 8 * NIN + 20, 20'h80000, 8, 20'h7FFFF, 20'hFFFFF, 20'h00000};
    tbl[5] = '{30, 20'h70000, 9 * NIN + 30, 20'h10000, 9, 20'h20000, 20'h7FFFF, 20'h7FFFF};

    reset = 1'b1;
    start = 1'b0;
    clearMems();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset_ctrl%0d", i), actBundle(i), '0);
      checkOutput($sformatf("reset_data%0d", i), fc_data[i], '0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] saturation run with full address/timing sweep");
    for (int j = 0; j < NIN; j++) l1_mem[j] = 20'h10000;
    for (int j = 0; j < NOUT * NIN; j++) w_mem[j] = 20'h10000;
    runOnce(1, -1, -1);
    checkResults("sat");
    for (int o = 0; o < NOUT; o++)
      checkOutput($sformatf("sat_const_out%0d", o), res[0][o], 20'h7FFFF);

    $display("[TB] directed sign/bias/rounding table");
    clearMems();
    for (int v = 0; v < 6; v++) applyStimulus(v);
    runOnce(0, -1, -1);
    checkResults("table");
    for (int v = 0; v < 6; v++) begin
      checkOutput($sformatf("table%0d_relu0", v), res[0][tbl[v].o_idx], tbl[v].exp0);
      checkOutput($sformatf("table%0d_relu1", v), res[1][tbl[v].o_idx], tbl[v].exp1);
    end

    $display("[TB] restart-while-busy and mid-run reset");
    randomMems(1024);
    runOnce(1, 300, 500);
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", actBundle(0), '0);

    $display("[TB] random runs after reset");
    runOnce(1, -1, -1);
    checkResults("rand_small");
    randomMems(16384);
    runOnce(0, -1, -1);
    checkResults("rand_large");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
